dmem_access_unit: RTL and testbench
===================================

Name: dmem_access_unit

Overview:
- Initiator-side load/store unit sitting between the single-cycle core's execute stage and the word-addressed data memory.
- Accepts one RV32I load/store request per handshake and drives the memory's addr/din/mem_read/mem_write.
- Sub-word stores are performed as a read-modify-write; load results are extracted and sign- or zero-extended.
- Returns one response per request: load data, or an error flag for misaligned or out-of-range addresses.

Parameters:
- MEM_BYTES, 65536, byte size of the attached data memory; any access at or above this byte address is an error.
- ADDR_W, 32, width of request and memory addresses.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign code: LB=000, LH=001, LW=010, LBU=100, LHU=101; stores use 000/001/010.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, taken from the low bits for SB and SH.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  extended load data; 0 for stores and for errors.
- rsp_err  out  1  misaligned or out-of-range access.
- mem_addr  out  ADDR_W  byte address to memory; bits [1:0] are always driven 0.
- mem_din  out  32  write word.
- mem_read  out  1  memory read enable; memory read data is asynchronous.
- mem_write  out  1  memory write enable; the write is committed on the next rising clk edge.
- mem_dout  in  32  read word from memory.

Behaviour:
- Reset values (while reset is low): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_read=0, mem_write=0, mem_addr=0, mem_din=0.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - On req_valid && req_ready, register the request.
  - If misaligned or address+size > MEM_BYTES: go to RESP with rsp_err=1. No memory access is made.
  - Otherwise, a load or SB/SH goes to RD; SW goes to WR.
- RD (one cycle): mem_read=1, mem_addr={addr[31:2],2'b00}. Capture mem_dout at the clk edge.
  - Load: extract the lane and extend into rsp_rdata, then go to RESP.
  - SB/SH: merge req_wdata into the captured word, then go to WR.
- WR (one cycle): mem_write=1, mem_din = full word (SW) or merged word (SB/SH). Then go to RESP.
- RESP: rsp_valid=1 with rdata/err held stable until rsp_ready=1. After acceptance, return to IDLE with req_ready=1 in the next cycle.
- Latency from acceptance edge to rsp_valid:
  - LW/LB/LH/LBU/LHU: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
- Misalignment rules: halfword requires addr[0]=0; word requires addr[1:0]=00. A reserved funct3 (011, 11x, or a store with funct3 bit 2 set) is also treated as an error.
- mem_read and mem_write are never asserted in the same cycle, and both are 0 in IDLE and RESP.
- Extension: LB/LH replicate the sign bit; LBU/LHU zero-fill.
- A new request is not accepted while a response is pending; there is no pipelining.
- Reset asserted mid-operation aborts immediately. A write already presented in WR may or may not commit, depending on the edge; the bench must not check memory in that case.

Optional Feature:
- Macro: DMEM_ACCESS_STATS_EN.
- When defined, adds three outputs: stat_loads [31:0], stat_stores [31:0], stat_errs [31:0].
  - Each counter increments on response acceptance of the matching kind.
  - Counters wrap at 2^32 and clear on reset.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Package dmem_access_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state encoding;
  - a size-in-bytes function of funct3.
- One combinational sub-module, dmem_lane_align, handles both directions:
  - load side: extract + extend, from word, addr[1:0] and funct3;
  - store side: merge, from old word, wdata, addr[1:0] and funct3.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF, then LW 0x100 → single mem_write cycle with mem_din=0xDEADBEEF; LW response rdata=0xDEADBEEF, err=0, 2 cycles after acceptance.
- Preload 0xDEADBEEF at 0x100, then SB addr 0x101, wdata 0x000000AA → RD then WR; mem_din=0xDEADAAEF; LW 0x100 returns 0xDEADAAEF.
- Word 0x8000F080 at 0x200:
  - LB 0x200 → 0xFFFFFF80;
  - LBU 0x200 → 0x00000080;
  - LH 0x202 → 0xFFFF8000;
  - LHU 0x202 → 0x00008000.
- LW 0x102 and SH 0x103 → rsp_err=1, rdata=0, 1-cycle latency, mem_read and mem_write stay 0 throughout.
- LW at MEM_BYTES-4 → OK; LW at MEM_BYTES → err=1. Hold rsp_ready=0 for 5 cycles → rsp_valid, rsp_rdata and rsp_err stay stable and req_ready=0.
- Drive reset low during RD → all outputs return to reset values asynchronously; after release, a fresh LW completes normally. With DMEM_ACCESS_STATS_EN defined, counters read 0 after reset.

Source files
------------

// File: rtl/dmem_access_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 codes, FSM states
// and the access-size helper.
package dmem_access_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_RESP = 2'd3
   } state_t;

   // A size of zero marks a reserved funct3 encoding.
   function automatic logic [2:0] size_bytes(input logic [2:0] f3);
      case (f3)
         F3_B, F3_BU: size_bytes = 3'd1;
         F3_H, F3_HU: size_bytes = 3'd2;
         F3_W:        size_bytes = 3'd4;
         default:     size_bytes = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between a memory word and a sub-word access: load-side
// extract/extend and store-side merge into the old word.
module dmem_lane_align
   import dmem_access_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [31:0] i_wdata,
   input  logic [1:0]  i_offset,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_load,
   output logic [31:0] o_merge
);

   logic [31:0] w_shifted;

   always_comb begin
      w_shifted = i_word >> {i_offset, 3'b000};
      o_load    = '0;
      case (i_funct3)
         F3_B:    o_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
         F3_H:    o_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
         F3_W:    o_load = i_word;
         F3_BU:   o_load = {24'd0, w_shifted[7:0]};
         F3_HU:   o_load = {16'd0, w_shifted[15:0]};
         default: o_load = '0;
      endcase
   end

   always_comb begin
      o_merge = i_word;
      case (i_funct3)
         F3_B:    o_merge[{i_offset, 3'b000} +: 8]     = i_wdata[7:0];
         F3_H:    o_merge[{i_offset[1], 4'b0000} +: 16] = i_wdata[15:0];
         F3_W:    o_merge = i_wdata;
         default: o_merge = i_word;
      endcase
   end

endmodule

// File: rtl/dmem_access_unit.sv
// RV32I load/store unit for a word-addressed data memory; sub-word stores use
// read-modify-write. Optional counters enabled by DMEM_ACCESS_STATS_EN.
module dmem_access_unit
   import dmem_access_pkg::*;
#(
   parameter int MEM_BYTES = 65536,
   parameter int ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_din,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [31:0]       mem_dout
`ifdef DMEM_ACCESS_STATS_EN
   ,
   output logic [31:0]       stat_loads,
   output logic [31:0]       stat_stores,
   output logic [31:0]       stat_errs
`endif
);

   state_t            r_state;
   state_t            w_nextState;
   logic              r_we;
   logic [2:0]        r_f3;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_rdata;
   logic              r_err;

   logic [2:0]        w_size;
   logic [ADDR_W:0]   w_end;
   logic              w_reqErr;
   logic [31:0]       w_loadData;
   logic [31:0]       w_mergeData;

   // The end address is one bit wider so accesses near the top of the address space cannot wrap.
   assign w_size   = size_bytes(req_funct3);
   assign w_end    = {1'b0, req_addr} + {{(ADDR_W-2){1'b0}}, w_size};
   assign w_reqErr = (w_size == 3'd0) || (req_we && req_funct3[2])
                   || ((w_size == 3'd2) && req_addr[0])
                   || ((w_size == 3'd4) && (req_addr[1:0] != 2'b00))
                   || (w_end > (ADDR_W+1)'(MEM_BYTES));

   dmem_lane_align u_lane (
      .i_word   (mem_dout),
      .i_wdata  (r_wdata),
      .i_offset (r_addr[1:0]),
      .i_funct3 (r_f3),
      .o_load   (w_loadData),
      .o_merge  (w_mergeData)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_addr    = '0;
      mem_din     = '0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (w_reqErr)                         w_nextState = S_RESP;
               else if (req_we && req_funct3 == F3_W) w_nextState = S_WR;
               else                                  w_nextState = S_RD;
            end
         end
         S_RD: begin
            mem_read    = 1'b1;
            mem_addr    = {r_addr[ADDR_W-1:2], 2'b00};
            w_nextState = r_we ? S_WR : S_RESP;
         end
         S_WR: begin
            mem_write   = 1'b1;
            mem_addr    = {r_addr[ADDR_W-1:2], 2'b00};
            mem_din     = r_wdata;
            w_nextState = S_RESP;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) w_nextState = S_IDLE;
         end
         default: w_nextState = S_IDLE;
      endcase
   end

   // For sub-word stores r_wdata is overwritten with the merged word so WR just writes it out.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_we    <= 1'b0;
         r_f3    <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_we    <= req_we;
                  r_f3    <= req_funct3;
                  r_addr  <= req_addr;
                  r_wdata <= req_wdata;
                  r_rdata <= '0;
                  r_err   <= w_reqErr;
               end
            end
            S_RD: begin
               if (r_we) r_wdata <= w_mergeData;
               else      r_rdata <= w_loadData;
            end
            default: ;
         endcase
      end
   end

   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;

`ifdef DMEM_ACCESS_STATS_EN
   logic [31:0] r_statLoads;
   logic [31:0] r_statStores;
   logic [31:0] r_statErrs;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_statLoads  <= '0;
         r_statStores <= '0;
         r_statErrs   <= '0;
      end else if (r_state == S_RESP && rsp_ready) begin
         if (r_err)     r_statErrs   <= r_statErrs + 32'd1;
         else if (r_we) r_statStores <= r_statStores + 32'd1;
         else           r_statLoads  <= r_statLoads + 32'd1;
      end
   end

   assign stat_loads  = r_statLoads;
   assign stat_stores = r_statStores;
   assign stat_errs   = r_statErrs;
`endif

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit with a behavioural word memory; also builds
// with DMEM_ACCESS_STATS_EN defined to exercise the counters.
module tb_dmem_access_unit;

   localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      longint      acceptTime;
      int          hold;
   } rsp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clk;
   logic        reset;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic [31:0] mem_addr, mem_din, mem_dout;
   logic        mem_read, mem_write;
`ifdef DMEM_ACCESS_STATS_EN
   logic [31:0] stat_loads, stat_stores, stat_errs;
`endif

   logic [31:0] memArr [0:16383];
   logic        preloadEn;
   logic [31:0] preloadAddr, preloadData;

   rsp_t expQ[$];
   wr_t  wrQ[$];
   int   errors = 0;
   int   checks = 0;
   int   accessCount = 0;

   dmem_access_unit dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_dout   (mem_dout)
`ifdef DMEM_ACCESS_STATS_EN
      ,
      .stat_loads  (stat_loads),
      .stat_stores (stat_stores),
      .stat_errs   (stat_errs)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Asynchronous-read memory; the bench preloads words through the same write port.
   assign mem_dout = memArr[mem_addr[15:2]];
   always @(posedge clk) begin
      if (preloadEn)      memArr[preloadAddr[15:2]] <= preloadData;
      else if (mem_write) memArr[mem_addr[15:2]]    <= mem_din;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      preloadEn   = 1'b1;
      preloadAddr = addr;
      preloadData = data;
      @(negedge clk);
      preloadEn   = 1'b0;
   endtask

   task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] expRdata,
                                input logic expErr, input int lat, input int hold);
      int   waitCnt;
      rsp_t e;
      waitCnt = 0;
      @(negedge clk);
      while (!req_ready && waitCnt < 200) begin
         @(negedge clk);
         waitCnt++;
      end
      if (!req_ready) begin
         checkOutput("req_ready_timeout", 64'(req_ready), 64'd1);
         return;
      end
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk);
      e.rdata      = expRdata;
      e.err        = expErr;
      e.lat        = lat;
      e.acceptTime = longint'($time);
      e.hold       = hold;
      expQ.push_back(e);
      #1 req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((expQ.size() != 0 || wrQ.size() != 0 || !req_ready) && n < 500) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain_pending", 64'(expQ.size() + wrQ.size()), 64'd0);
   endtask

   task automatic pushWrite(input logic [31:0] addr, input logic [31:0] data);
      wr_t w;
      w.addr = addr;
      w.data = data;
      wrQ.push_back(w);
   endtask

   // Monitor: checks memory-side activity and pops the scoreboard on each response.
   initial begin
      bit   seen;
      int   held;
      int   lat;
      rsp_t e;
      wr_t  w;
      seen = 0;
      held = 0;
      rsp_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            seen = 0;
            held = 0;
            rsp_ready = 1'b0;
         end else begin
            if (mem_read && mem_write) checkOutput("rd_wr_exclusive", 64'd1, 64'd0);
            if (mem_read || mem_write) accessCount++;
            if (mem_write) begin
               if (wrQ.size() == 0) begin
                  checkOutput("unexpected_write", {mem_addr, mem_din}, 64'hFFFF_FFFF_FFFF_FFFF);
               end else begin
                  w = wrQ.pop_front();
                  checkOutput("write_addr_data", {mem_addr, mem_din}, {w.addr, w.data});
               end
            end
            if (rsp_valid) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpected_rsp", {rsp_rdata, 31'd0, rsp_err}, 64'hFFFF_FFFF_FFFF_FFFF);
                  rsp_ready = 1'b1;
               end else begin
                  e = expQ[0];
                  if (!seen) begin
                     seen = 1;
                     held = 0;
                     lat  = int'((longint'($time) - e.acceptTime + 5) / 10);
                     checkOutput("rsp_data_err", {rsp_rdata, 31'd0, rsp_err}, {e.rdata, 31'd0, e.err});
                     checkOutput("rsp_latency", 64'(lat), 64'(e.lat));
                  end else begin
                     checkOutput("rsp_hold_stable", {rsp_rdata, 30'd0, rsp_err, req_ready},
                                 {e.rdata, 30'd0, e.err, 1'b0});
                  end
                  if (held < e.hold) begin
                     rsp_ready = 1'b0;
                     held++;
                  end else begin
                     rsp_ready = 1'b1;
                     void'(expQ.pop_front());
                     seen = 0;
                  end
               end
            end else begin
               rsp_ready = 1'b0;
            end
         end
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int snap;
      reset       = 1'b0;
      req_valid   = 1'b0;
      req_we      = 1'b0;
      req_funct3  = '0;
      req_addr    = '0;
      req_wdata   = '0;
      preloadEn   = 1'b0;
      preloadAddr = '0;
      preloadData = '0;
      #1;
      checkOutput("reset_ctrl", {mem_addr, 27'd0, req_ready, rsp_valid, rsp_err, mem_read, mem_write},
                  {32'd0, 27'd0, 5'b10000});
      checkOutput("reset_data", {rsp_rdata, mem_din}, 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Word store then load back.
      pushWrite(32'h100, 32'hDEADBEEF);
      applyStimulus(1'b1, LW, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0);
      applyStimulus(1'b0, LW, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);
      drain();

      // Byte store into lane 1 via read-modify-write.
      preload(32'h100, 32'hDEADBEEF);
      pushWrite(32'h100, 32'hDEADAAEF);
      applyStimulus(1'b1, LB, 32'h101, 32'h000000AA, 32'h0, 1'b0, 3, 0);
      applyStimulus(1'b0, LW, 32'h100, 32'h0, 32'hDEADAAEF, 1'b0, 2, 0);
      drain();

      // Sign and zero extension.
      preload(32'h200, 32'h8000F080);
      applyStimulus(1'b0, LB,  32'h200, 32'h0, 32'hFFFFFF80, 1'b0, 2, 0);
      applyStimulus(1'b0, LBU, 32'h200, 32'h0, 32'h00000080, 1'b0, 2, 0);
      applyStimulus(1'b0, LH,  32'h202, 32'h0, 32'hFFFF8000, 1'b0, 2, 0);
      applyStimulus(1'b0, LHU, 32'h202, 32'h0, 32'h00008000, 1'b0, 2, 0);
      drain();

      // Halfword store into the upper half, then sub-word reads of the result.
      preload(32'h300, 32'h11223344);
      pushWrite(32'h300, 32'h12343344);
      applyStimulus(1'b1, LH,  32'h302, 32'hFFFF1234, 32'h0, 1'b0, 3, 0);
      applyStimulus(1'b0, LHU, 32'h300, 32'h0, 32'h00003344, 1'b0, 2, 0);
      applyStimulus(1'b0, LB,  32'h303, 32'h0, 32'h00000012, 1'b0, 2, 0);
      drain();

      // Misaligned and reserved encodings must not touch memory.
      snap = accessCount;
      applyStimulus(1'b0, LW,     32'h102, 32'h0, 32'h0, 1'b1, 1, 0);
      applyStimulus(1'b1, LH,     32'h103, 32'h5555, 32'h0, 1'b1, 1, 0);
      applyStimulus(1'b0, 3'b011, 32'h000, 32'h0, 32'h0, 1'b1, 1, 0);
      applyStimulus(1'b1, 3'b100, 32'h100, 32'h77, 32'h0, 1'b1, 1, 0);
      drain();
      checkOutput("err_no_mem_access", 64'(accessCount), 64'(snap));

      // Top-of-memory boundary, with the out-of-range response held for 5 cycles.
      preload(32'hFFFC, 32'hCAFEF00D);
      applyStimulus(1'b0, LW, 32'hFFFC,  32'h0, 32'hCAFEF00D, 1'b0, 2, 0);
      applyStimulus(1'b0, LH, 32'hFFFE,  32'h0, 32'hFFFFCAFE, 1'b0, 2, 0);
      applyStimulus(1'b0, LW, 32'h10000, 32'h0, 32'h0, 1'b1, 1, 5);
      drain();

      // Reset while the unit is in RD.
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = LW;
      req_addr   = 32'h200;
      @(posedge clk);
      #1 req_valid = 1'b0;
      checkOutput("in_rd_before_reset", 64'(mem_read), 64'd1);
      #2 reset = 1'b0;
      #1;
      checkOutput("midop_reset_ctrl", {mem_addr, 27'd0, req_ready, rsp_valid, rsp_err, mem_read, mem_write},
                  {32'd0, 27'd0, 5'b10000});
      checkOutput("midop_reset_data", {rsp_rdata, mem_din}, 64'd0);
`ifdef DMEM_ACCESS_STATS_EN
      checkOutput("stats_after_reset", {stat_loads, stat_stores}, 64'd0);
      checkOutput("stat_errs_after_reset", 64'(stat_errs), 64'd0);
`endif
      repeat (2) @(negedge clk);
      reset = 1'b1;
      applyStimulus(1'b0, LW, 32'h200, 32'h0, 32'h8000F080, 1'b0, 2, 0);
      drain();
`ifdef DMEM_ACCESS_STATS_EN
      checkOutput("stats_final", {stat_loads, stat_stores}, {32'd1, 32'd0});
      checkOutput("stat_errs_final", 64'(stat_errs), 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
